// File: rtl/alu_cmd_seq_pkg.sv
// rtl/alu_cmd_seq_pkg.sv - shared opcodes, flag indices, FSM state and command record for the ALU sequencer
package alu_cmd_seq_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1100;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic wr_en;
        logic illegal;
    } cmd_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_MUL, OP_SHL, OP_SHR,
            OP_AND, OP_OR, OP_XOR, OP_NOT: op_is_legal = 1'b1;
            default:                       op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_seq_regfile.sv
// rtl/alu_cmd_seq_regfile.sv - NREGS x 8 register file, two async read ports, one sync write port
module alu_cmd_seq_regfile
    import alu_cmd_seq_pkg::*;
#(
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command/response sequencer driving an external combinational 8-bit alu
// Optional overflow trap on add/sub results: define ALU_CMD_SEQ_TRAP_EN.
module alu_cmd_sequencer
    import alu_cmd_seq_pkg::*;
#(
    parameter int NREGS       = 4,
    parameter int WAIT_CYCLES = 1,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic [3:0]        Cmd_Op,
    input  logic              Cmd_Sub,
    input  logic [REG_AW-1:0] Cmd_Ra,
    input  logic [REG_AW-1:0] Cmd_Rb,
    input  logic [REG_AW-1:0] Cmd_Rd,
    input  logic              Cmd_ImmSel,
    input  logic [7:0]        Cmd_Imm,
    input  logic              Cmd_WrEn,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [7:0]        Rsp_Data,
    output logic [3:0]        Rsp_Flags,
    output logic              Rsp_Err,
    output logic [7:0]        ALU_A,
    output logic [7:0]        ALU_B,
    output logic [3:0]        ALU_Sel,
    output logic              ALU_Sub,
    input  logic [7:0]        ALU_Out,
    input  logic              ALU_CarryOut,
    input  logic              ALU_ZeroFlag,
    input  logic              ALU_OverflowFlag,
    input  logic              ALU_SignFlag
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    cmd_t              cmd_q, cmd_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [7:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic              alu_sub_q, alu_sub_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;

    logic [7:0]        rdata_a, rdata_b;
    logic              wb_en;
    logic              trap;
    logic              legal;

    alu_cmd_seq_regfile #(.NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (Cmd_Ra),
        .raddr_b (Cmd_Rb),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (wb_en),
        .waddr   (rd_q),
        .wdata   (ALU_Out)
    );

    // Illegal commands also present as Sel=0000, so they must not be mistaken for an add overflow.
`ifdef ALU_CMD_SEQ_TRAP_EN
    assign trap = (alu_sel_q == OP_ADD) && !cmd_q.illegal && ALU_OverflowFlag;
`else
    assign trap = 1'b0;
`endif

    assign legal     = op_is_legal(Cmd_Op);
    assign Cmd_Ready = (state_q == ST_IDLE) && !rst;
    assign Rsp_Valid = (state_q == ST_RESP) && !rst;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        rd_d        = rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        alu_sub_d   = alu_sub_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        wb_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Cmd_Valid && Cmd_Ready) begin
                    cmd_d.wr_en   = Cmd_WrEn;
                    cmd_d.illegal = !legal;
                    rd_d          = Cmd_Rd;
                    alu_a_d       = rdata_a;
                    alu_b_d       = Cmd_ImmSel ? Cmd_Imm : rdata_b;
                    alu_sel_d     = legal ? Cmd_Op : OP_ADD;
                    alu_sub_d     = legal && (Cmd_Op == OP_ADD) && Cmd_Sub;
                    cnt_d         = '0;
                    state_d       = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    if (cmd_q.illegal) begin
                        rsp_data_d  = '0;
                        rsp_flags_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        rsp_data_d          = ALU_Out;
                        rsp_flags_d[FLAG_C] = ALU_CarryOut;
                        rsp_flags_d[FLAG_Z] = ALU_ZeroFlag;
                        rsp_flags_d[FLAG_V] = ALU_OverflowFlag;
                        rsp_flags_d[FLAG_S] = ALU_SignFlag;
                        rsp_err_d           = trap;
                    end
                    wb_en   = cmd_q.wr_en && !cmd_q.illegal && !trap;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (Rsp_Ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_sub_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            rd_q        <= rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_sub_q   <= alu_sub_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_Sel   = alu_sel_q;
    assign ALU_Sub   = alu_sub_q;
    assign Rsp_Data  = rsp_data_q;
    assign Rsp_Flags = rsp_flags_q;
    assign Rsp_Err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed vector bench for alu_cmd_sequencer with a behavioural alu
module tb_alu_cmd_sequencer;

`ifdef ALU_CMD_SEQ_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Cmd_Valid = 1'b0;
    logic       Cmd_Ready;
    logic [3:0] Cmd_Op = '0;
    logic       Cmd_Sub = 1'b0;
    logic [1:0] Cmd_Ra = '0, Cmd_Rb = '0, Cmd_Rd = '0;
    logic       Cmd_ImmSel = 1'b0;
    logic [7:0] Cmd_Imm = '0;
    logic       Cmd_WrEn = 1'b0;
    logic       Rsp_Valid;
    logic       Rsp_Ready = 1'b0;
    logic [7:0] Rsp_Data;
    logic [3:0] Rsp_Flags;
    logic       Rsp_Err;
    logic [7:0] ALU_A, ALU_B;
    logic [3:0] ALU_Sel;
    logic       ALU_Sub;
    logic [7:0] ALU_Out;
    logic       ALU_CarryOut, ALU_ZeroFlag, ALU_OverflowFlag, ALU_SignFlag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.NREGS(4), .WAIT_CYCLES(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .Cmd_Valid        (Cmd_Valid),
        .Cmd_Ready        (Cmd_Ready),
        .Cmd_Op           (Cmd_Op),
        .Cmd_Sub          (Cmd_Sub),
        .Cmd_Ra           (Cmd_Ra),
        .Cmd_Rb           (Cmd_Rb),
        .Cmd_Rd           (Cmd_Rd),
        .Cmd_ImmSel       (Cmd_ImmSel),
        .Cmd_Imm          (Cmd_Imm),
        .Cmd_WrEn         (Cmd_WrEn),
        .Rsp_Valid        (Rsp_Valid),
        .Rsp_Ready        (Rsp_Ready),
        .Rsp_Data         (Rsp_Data),
        .Rsp_Flags        (Rsp_Flags),
        .Rsp_Err          (Rsp_Err),
        .ALU_A            (ALU_A),
        .ALU_B            (ALU_B),
        .ALU_Sel          (ALU_Sel),
        .ALU_Sub          (ALU_Sub),
        .ALU_Out          (ALU_Out),
        .ALU_CarryOut     (ALU_CarryOut),
        .ALU_ZeroFlag     (ALU_ZeroFlag),
        .ALU_OverflowFlag (ALU_OverflowFlag),
        .ALU_SignFlag     (ALU_SignFlag)
    );

    // Behavioural alu; mul multiplies the upper nibbles of A and B.
    logic [8:0] sum;
    logic [7:0] alu_r;
    logic       alu_c, alu_v;
    always_comb begin
        sum   = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (ALU_Sel)
            4'b0000: begin
                if (ALU_Sub) begin
                    sum   = {1'b0, ALU_A} + {1'b0, ~ALU_B} + 9'd1;
                    alu_v = (ALU_A[7] != ALU_B[7]) && (sum[7] != ALU_A[7]);
                end else begin
                    sum   = {1'b0, ALU_A} + {1'b0, ALU_B};
                    alu_v = (ALU_A[7] == ALU_B[7]) && (sum[7] != ALU_A[7]);
                end
                alu_r = sum[7:0];
                alu_c = sum[8];
            end
            4'b0010: alu_r = {4'b0, ALU_A[7:4]} * {4'b0, ALU_B[7:4]};
            4'b0100: {alu_c, alu_r} = {ALU_A, 1'b0};
            4'b0101: begin
                alu_r = {1'b0, ALU_A[7:1]};
                alu_c = ALU_A[0];
            end
            4'b1000: alu_r = ALU_A & ALU_B;
            4'b1001: alu_r = ALU_A | ALU_B;
            4'b1010: alu_r = ALU_A ^ ALU_B;
            4'b1100: alu_r = ~ALU_A;
            default: alu_r = '0;
        endcase
    end
    assign ALU_Out          = alu_r;
    assign ALU_CarryOut     = alu_c;
    assign ALU_ZeroFlag     = (alu_r == 8'h00);
    assign ALU_OverflowFlag = alu_v;
    assign ALU_SignFlag     = alu_r[7];

    typedef struct {
        logic [3:0] op;
        logic       sub;
        logic [1:0] ra, rb, rd;
        logic       imm_sel;
        logic [7:0] imm;
        logic       wr;
        logic [7:0] e_data;
        logic [3:0] e_flags;
        logic       e_err;
        logic [3:0] e_sel;
        logic       e_sub;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one command; checks latency, alu drive and response, then completes the handshake.
    task automatic run_cmd(input vec_t v, input int idx);
        int n;
        logic [3:0] sel_seen;
        logic       sub_seen;
        n = 0;
        @(negedge clk);
        while (!Cmd_Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!Cmd_Ready) begin
            chk($sformatf("v%0d_ready_timeout", idx), 0, 1);
            return;
        end
        Cmd_Op     = v.op;
        Cmd_Sub    = v.sub;
        Cmd_Ra     = v.ra;
        Cmd_Rb     = v.rb;
        Cmd_Rd     = v.rd;
        Cmd_ImmSel = v.imm_sel;
        Cmd_Imm    = v.imm;
        Cmd_WrEn   = v.wr;
        Cmd_Valid  = 1'b1;
        @(posedge clk);
        #1;
        Cmd_Valid = 1'b0;
        sel_seen  = ALU_Sel;
        sub_seen  = ALU_Sub;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!Rsp_Valid && n < 20);
        chk($sformatf("v%0d_latency", idx), n, 2);
        chk($sformatf("v%0d_alu_sel", idx), sel_seen, v.e_sel);
        chk($sformatf("v%0d_alu_sub", idx), sub_seen, v.e_sub);
        chk($sformatf("v%0d_data", idx), Rsp_Data, v.e_data);
        chk($sformatf("v%0d_flags", idx), Rsp_Flags, v.e_flags);
        chk($sformatf("v%0d_err", idx), Rsp_Err, v.e_err);
        Rsp_Ready = 1'b1;
        @(posedge clk);
        #1;
        Rsp_Ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   n;
        //          op    sub ra rb rd isel imm   wr  data   flags    err   sel   sub
        vecs[0]  = '{4'h9, 0, 0, 0, 1, 1, 8'h7F, 1, 8'h7F, 4'b0000, 1'b0, 4'h9, 0};
        vecs[1]  = '{4'h0, 0, 1, 0, 2, 1, 8'h01, 1, 8'h80, 4'b0011, TRAP, 4'h0, 0};
        vecs[2]  = '{4'h0, 1, 1, 0, 3, 1, 8'h7F, 0, 8'h00, 4'b1100, 1'b0, 4'h0, 1};
        vecs[3]  = '{4'h2, 0, 1, 0, 3, 1, 8'h30, 0, 8'h15, 4'b0000, 1'b0, 4'h2, 0};
        vecs[4]  = '{4'h7, 1, 1, 0, 1, 1, 8'h55, 1, 8'h00, 4'b0000, 1'b1, 4'h0, 0};
        vecs[5]  = '{4'h9, 0, 1, 0, 0, 1, 8'h00, 0, 8'h7F, 4'b0000, 1'b0, 4'h9, 0};
        vecs[6]  = '{4'h9, 0, 2, 0, 0, 1, 8'h00, 0, TRAP ? 8'h00 : 8'h80,
                     TRAP ? 4'b0100 : 4'b0001, 1'b0, 4'h9, 0};
        vecs[7]  = '{4'hA, 0, 1, 1, 3, 0, 8'h00, 1, 8'h00, 4'b0100, 1'b0, 4'hA, 0};
        vecs[8]  = '{4'hC, 0, 1, 0, 3, 1, 8'h00, 1, 8'h80, 4'b0001, 1'b0, 4'hC, 0};
        vecs[9]  = '{4'h8, 0, 3, 1, 0, 0, 8'h00, 0, 8'h00, 4'b0100, 1'b0, 4'h8, 0};
        vecs[10] = '{4'h4, 0, 1, 0, 0, 1, 8'h00, 1, 8'hFE, 4'b0001, 1'b0, 4'h4, 0};
        vecs[11] = '{4'h5, 0, 0, 0, 0, 1, 8'h00, 1, 8'h7F, 4'b0000, 1'b0, 4'h5, 0};
        vecs[12] = '{4'h0, 0, 0, 1, 1, 0, 8'h00, 0, 8'hFE, 4'b0011, TRAP, 4'h0, 0};
        vecs[13] = '{4'h9, 1, 0, 0, 0, 1, 8'h80, 0, 8'hFF, 4'b0001, 1'b0, 4'h9, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", Cmd_Ready, 0);
        chk("rst_rsp_valid", Rsp_Valid, 0);
        chk("rst_alu_a", ALU_A, 0);
        chk("rst_alu_b", ALU_B, 0);
        chk("rst_alu_sel_sub", {ALU_Sel, ALU_Sub}, 0);
        chk("rst_rsp", {Rsp_Data, Rsp_Flags, Rsp_Err}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", Cmd_Ready, 1);

        for (int i = 0; i < 14; i++) begin
            run_cmd(vecs[i], i);
        end

        // Back-pressure: response must hold while Rsp_Ready stays low.
        @(negedge clk);
        Cmd_Op = 4'h9; Cmd_Sub = 0; Cmd_Ra = 2'd1; Cmd_Rb = 0; Cmd_Rd = 0;
        Cmd_ImmSel = 1; Cmd_Imm = 8'h00; Cmd_WrEn = 0; Cmd_Valid = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!Rsp_Valid && n < 20);
        chk("bp_valid", Rsp_Valid, 1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_hold%0d", c), {Rsp_Valid, Cmd_Ready, Rsp_Data, Rsp_Flags, Rsp_Err},
                {1'b1, 1'b0, 8'h7F, 4'b0000, 1'b0});
            @(negedge clk);
        end
        Cmd_Valid = 1'b0;
        Rsp_Ready = 1'b1;
        @(posedge clk);
        #1;
        Rsp_Ready = 1'b0;

        // Reset while in DRIVE: abandoned command, no response, register file cleared.
        @(negedge clk);
        chk("bp_back_idle", Cmd_Ready, 1);
        Cmd_Op = 4'h0; Cmd_Sub = 0; Cmd_Ra = 2'd1; Cmd_Rd = 2'd2;
        Cmd_ImmSel = 1; Cmd_Imm = 8'h01; Cmd_WrEn = 1; Cmd_Valid = 1'b1;
        @(posedge clk);
        #1;
        Cmd_Valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", Rsp_Valid, 0);
        chk("mid_rst_ready", Cmd_Ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_no_rsp%0d", c), Rsp_Valid, 0);
        end
        chk("post_rst_alu", {ALU_A, ALU_B, ALU_Sel, ALU_Sub}, 0);
        v = '{4'h9, 0, 1, 2, 0, 0, 8'h00, 0, 8'h00, 4'b0100, 1'b0, 4'h9, 0};
        run_cmd(v, 100);
        v = '{4'h9, 0, 0, 3, 0, 0, 8'h00, 0, 8'h00, 4'b0100, 1'b0, 4'h9, 0};
        run_cmd(v, 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
